// File: rtl/l1_i_pkg.sv
// Shared types and constants for the N-way L1 instruction-cache controller.
package l1_i_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam int BLK_W    = 26;
  localparam int LINE_OFF = 6;

endpackage

// File: rtl/l1_i_plru_tree.sv
// Combinational tree pseudo-LRU: applies an access to one set's tree bits and
// reports the victim way found by following the node pointers (0 = left).
module l1_i_plru_tree
  import l1_i_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_tree,
  input  logic [$clog2(WAYS)-1:0] i_way,
  output logic [WAYS-2:0]         o_tree,
  output logic [$clog2(WAYS)-1:0] o_victim
);

  localparam int WNUM = $clog2(WAYS);
  localparam int TW   = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  int              w_node_upd;
  int              w_node_vic;
  logic [WNUM-1:0] w_path;

  // Heap layout: node n has children 2n+1 (left) and 2n+2 (right).
  always_comb begin
    o_tree     = i_tree;
    o_victim   = '0;
    w_path     = i_way;
    w_node_upd = 0;
    w_node_vic = 0;
    for (int l = 0; l < WNUM; l++) begin
      o_tree[TW'(w_node_upd)] = ~w_path[WNUM-1];
      w_node_upd = 2 * w_node_upd + 1 + int'(w_path[WNUM-1]);
      w_path     = w_path << 1;
    end
    for (int l = 0; l < WNUM; l++) begin
      o_victim   = (o_victim << 1) | WNUM'(i_tree[TW'(w_node_vic)]);
      w_node_vic = 2 * w_node_vic + 1 + int'(i_tree[TW'(w_node_vic)]);
    end
  end

endmodule

// File: rtl/l1_i_nway_controller.sv
// N-way set-associative L1 I-cache tag/valid controller with tree PLRU and
// sequential flush. Optional hit/miss counters under L1_I_PERF_CNT_EN.
module l1_i_nway_controller
  import l1_i_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int TNUM   = 21,
  parameter int INUM   = BLK_W - TNUM,
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = BLK_W - TNUM_2,
  parameter int WNUM   = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [TNUM-1:0]   tag_C_L1,
  input  logic [INUM-1:0]   index_C_L1,
  input  logic              read_C_L1,
  input  logic              flush,
  input  logic              ready_L2_L1,
  output logic              stall,
  output logic              refill,
  output logic [WNUM-1:0]   way,
  output logic              read_L1_L2,
  output logic [INUM_2-1:0] index_L1_L2,
  output logic [TNUM_2-1:0] tag_L1_L2,
  output logic [1:0]        o_dbg_state
`ifdef L1_I_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int SETS = 2 ** INUM;

  logic [TNUM-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-2:0] r_plru  [SETS];

  state_t          r_state, w_next;
  logic [TNUM-1:0] r_tag_l;
  logic [INUM-1:0] r_index_l, r_cnt;
  logic [WNUM-1:0] r_victim;
  logic            r_read, r_refill, r_pend;

  logic            w_match, w_hit, w_any_inv;
  logic [WNUM-1:0] w_hit_way, w_inv_way, w_plru_victim, w_victim, w_acc_way;
  logic [INUM-1:0] w_sel_idx;
  logic [WAYS-2:0] w_tree_upd;
  logic [BLK_W-1:0] w_blk;

  // Lowest-numbered match and lowest-numbered invalid way win.
  always_comb begin
    w_match   = 1'b0;
    w_hit_way = '0;
    w_any_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[index_C_L1][WNUM'(w)] && r_tag[index_C_L1][WNUM'(w)] == tag_C_L1) begin
        w_match   = 1'b1;
        w_hit_way = WNUM'(w);
      end
      if (!r_valid[index_C_L1][WNUM'(w)]) begin
        w_any_inv = 1'b1;
        w_inv_way = WNUM'(w);
      end
    end
  end

  assign w_hit     = read_C_L1 && w_match;
  assign w_victim  = w_any_inv ? w_inv_way : w_plru_victim;
  assign w_sel_idx = (r_state == REFILL) ? r_index_l : index_C_L1;
  assign w_acc_way = (r_state == REFILL) ? r_victim : w_hit_way;

  l1_i_plru_tree #(.WAYS(WAYS)) u_plru (
    .i_tree   (r_plru[w_sel_idx]),
    .i_way    (w_acc_way),
    .o_tree   (w_tree_upd),
    .o_victim (w_plru_victim)
  );

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    way    = '0;
    case (r_state)
      IDLE: begin
        if (read_C_L1) begin
          if (w_match) way = w_hit_way;
          else stall = 1'b1;
        end
        if (flush) w_next = FLUSH;
        else if (read_C_L1 && !w_match) w_next = MISS;
      end
      MISS: begin
        stall = 1'b1;
        if (ready_L2_L1) w_next = REFILL;
      end
      REFILL: begin
        stall  = 1'b1;
        way    = r_victim;
        w_next = (r_pend || flush) ? FLUSH : IDLE;
      end
      FLUSH: begin
        stall = 1'b1;
        if (r_cnt == INUM'(SETS - 1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!nrst) begin
      stall = 1'b0;
      way   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_tag_l   <= '0;
      r_index_l <= '0;
      r_cnt     <= '0;
      r_victim  <= '0;
      r_read    <= 1'b0;
      r_refill  <= 1'b0;
      r_pend    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[INUM'(s)] <= '0;
        r_plru[INUM'(s)]  <= '0;
      end
    end else begin
      r_state  <= w_next;
      r_refill <= (r_state == MISS) && ready_L2_L1;
      case (r_state)
        IDLE: begin
          if (!flush && read_C_L1) begin
            if (w_match) begin
              r_plru[index_C_L1] <= w_tree_upd;
            end else begin
              r_tag_l   <= tag_C_L1;
              r_index_l <= index_C_L1;
              r_victim  <= w_victim;
              r_read    <= 1'b1;
            end
          end
        end
        MISS: if (flush) r_pend <= 1'b1;
        REFILL: begin
          r_valid[r_index_l][r_victim] <= 1'b1;
          r_plru[r_index_l]            <= w_tree_upd;
          r_read                       <= 1'b0;
        end
        FLUSH: begin
          r_valid[r_cnt] <= '0;
          r_plru[r_cnt]  <= '0;
          r_pend         <= 1'b0;
          r_cnt          <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag storage needs no reset: valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (nrst && r_state == REFILL) r_tag[r_index_l][r_victim] <= r_tag_l;
  end

  assign w_blk       = {r_tag_l, r_index_l};
  assign tag_L1_L2   = w_blk[BLK_W-1 -: TNUM_2];
  assign index_L1_L2 = w_blk[INUM_2-1:0];
  assign read_L1_L2  = r_read;
  assign refill      = r_refill;
  assign o_dbg_state = r_state;

`ifdef L1_I_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 1'b1;
      if (r_state == IDLE && w_next == MISS && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_i_nway_controller.sv
// Directed + randomized bench for l1_i_nway_controller (WAYS=4, TNUM=21, INUM=5).
module tb_l1_i_nway_controller;
  import l1_i_pkg::*;

  localparam int WAYS = 4;
  localparam int TNUM = 21;
  localparam int INUM = 5;
  localparam int SETS = 32;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [20:0] tag_C_L1 = '0;
  logic [4:0]  index_C_L1 = '0;
  logic        read_C_L1 = 1'b0;
  logic        flush = 1'b0;
  logic        ready_L2_L1 = 1'b0;
  logic        stall, refill, read_L1_L2;
  logic [1:0]  way, dbg_state;
  logic [7:0]  index_L1_L2;
  logic [17:0] tag_L1_L2;
`ifdef L1_I_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  l1_i_nway_controller #(.WAYS(WAYS), .TNUM(TNUM)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .tag_C_L1    (tag_C_L1),
    .index_C_L1  (index_C_L1),
    .read_C_L1   (read_C_L1),
    .flush       (flush),
    .ready_L2_L1 (ready_L2_L1),
    .stall       (stall),
    .refill      (refill),
    .way         (way),
    .read_L1_L2  (read_L1_L2),
    .index_L1_L2 (index_L1_L2),
    .tag_L1_L2   (tag_L1_L2),
    .o_dbg_state (dbg_state)
`ifdef L1_I_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // reference model: tags, valids and last-access stamps per set/way
  logic [20:0] m_tag   [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_stamp [SETS][WAYS];
  int          m_time;
  int          m_hits, m_misses;
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_stamp[s][w] = 0;
      end
  endtask

  task automatic model_touch(input int s, input int w);
    m_time++;
    m_stamp[s][w] = m_time;
  endtask

  // Lowest invalid way, else descend toward the half whose newest access is older.
  function automatic int m_victim(input int s);
    int lo, size, half, ml, mr;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    lo = 0;
    size = WAYS;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int k = 0; k < half; k++) begin
        if (m_stamp[s][lo+k] > ml) ml = m_stamp[s][lo+k];
        if (m_stamp[s][lo+half+k] > mr) mr = m_stamp[s][lo+half+k];
      end
      if (mr < ml) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  // driver tasks
  task automatic do_reset();
    nrst = 1'b0;
    read_C_L1 = 1'b0;
    flush = 1'b0;
    ready_L2_L1 = 1'b0;
    cyc();
    cyc();
    nrst = 1'b1;
    model_flush();
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
    #1;
  endtask

  task automatic count_flush(input int hold_flush_cycles, output int n);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      if (n >= hold_flush_cycles) flush = 1'b0;
      cyc();
    end
    flush = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    read_C_L1 = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_idle_stall", stall, 0);
    cyc();
    count_flush(3, n);
    check("flush_len", n, SETS);
    model_flush();
  endtask

  task automatic access(input logic [31:0] addr, input int delay, input int exp_way,
                        input bit fl_miss);
    int s, hit_w, vic, n;
    logic [20:0] t;
    logic [25:0] blk;
    t = addr[31:11];
    s = int'(addr[10:6]);
    hit_w = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[s][w] && m_tag[s][w] == t) hit_w = w;
    tag_C_L1 = t;
    index_C_L1 = addr[10:6];
    read_C_L1 = 1'b1;
    #1;
    if (hit_w >= 0) begin
      check("hit_stall", stall, 0);
      check("hit_way", way, hit_w);
      if (exp_way >= 0) check("hit_way_plan", way, exp_way);
      cyc();
      model_touch(s, hit_w);
      m_hits++;
      read_C_L1 = 1'b0;
    end else begin
      vic = m_victim(s);
      check("miss_stall", stall, 1);
      exp_q.push_back(addr[31:6]);
      cyc();
      m_misses++;
      read_C_L1 = 1'($urandom_range(0, 1));
      tag_C_L1 = 21'($urandom);
      index_C_L1 = 5'($urandom);
      if (fl_miss) flush = 1'b1;
      #1;
      blk = exp_q.pop_front();
      check("miss_req", read_L1_L2, 1);
      check("miss_l2_tag", tag_L1_L2, blk[25:8]);
      check("miss_l2_index", index_L1_L2, blk[7:0]);
      for (int i = 0; i < delay; i++) begin
        cyc();
        flush = 1'b0;
        check("miss_hold_stall", stall, 1);
        check("miss_hold_tag", tag_L1_L2, blk[25:8]);
      end
      ready_L2_L1 = 1'b1;
      cyc();
      ready_L2_L1 = 1'b0;
      flush = 1'b0;
      #1;
      check("refill_strobe", refill, 1);
      check("refill_way", way, vic);
      check("refill_stall", stall, 1);
      if (exp_way >= 0) check("refill_way_plan", way, exp_way);
      cyc();
      read_C_L1 = 1'b0;
      m_tag[s][vic] = t;
      m_valid[s][vic] = 1'b1;
      model_touch(s, vic);
      #1;
      check("refill_one_cycle", refill, 0);
      check("req_cleared", read_L1_L2, 0);
      if (fl_miss) begin
        count_flush(0, n);
        check("pending_flush_len", n, SETS);
        model_flush();
      end else begin
        check("after_refill_stall", stall, 0);
      end
    end
  endtask

  function automatic logic [31:0] mk(input int tg, input int idx);
    return (32'(tg) << 11) | (32'(idx) << 6);
  endfunction

  logic [20:0] pool[6];

  initial begin
    do_reset();
    check("rst_stall", stall, 0);
    check("rst_req", read_L1_L2, 0);
    check("rst_refill", refill, 0);
    check("rst_way", way, 0);
    check("rst_l2_tag", tag_L1_L2, 0);
    check("rst_l2_index", index_L1_L2, 0);

    // first miss at 0x40 and its follow-up hit
    access(32'h0000_0040, 1, 0, 1'b0);
    access(32'h0000_0040, 0, 0, 1'b0);

    // idle with no read; ready outside MISS must be ignored
    read_C_L1 = 1'b0;
    ready_L2_L1 = 1'b1;
    #1;
    check("idle_noread_stall", stall, 0);
    cyc();
    ready_L2_L1 = 1'b0;
    #1;
    check("stray_ready_refill", refill, 0);
    check("stray_ready_req", read_L1_L2, 0);

    // fill four ways, then PLRU replacement
    do_reset();
    for (int t = 1; t <= 4; t++) access(mk(t, 1), 0, t - 1, 1'b0);
    access(mk(5, 1), 2, 0, 1'b0);
    access(mk(5, 1), 0, 0, 1'b0);
    access(mk(6, 1), 0, 2, 1'b0);

    // flush in IDLE, then all earlier lines miss
    do_flush();
    for (int t = 1; t <= 4; t++) access(mk(t, 1), 0, t - 1, 1'b0);

    // flush during MISS
    access(mk(9, 3), 1, -1, 1'b1);
    access(mk(9, 3), 0, 0, 1'b0);

    // reset during MISS
    access(mk(11, 2), 0, -1, 1'b0);
    tag_C_L1 = 21'd12;
    index_C_L1 = 5'd2;
    read_C_L1 = 1'b1;
    #1;
    check("pre_rst_miss_stall", stall, 1);
    cyc();
    nrst = 1'b0;
    #1;
    check("in_rst_stall", stall, 0);
    cyc();
    nrst = 1'b1;
    read_C_L1 = 1'b0;
    model_flush();
    m_hits = 0;
    m_misses = 0;
    #1;
    check("mid_rst_req", read_L1_L2, 0);
    check("mid_rst_stall", stall, 0);
    access(mk(11, 2), 0, -1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 6; i++) pool[i] = 21'($urandom);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        access({pool[$urandom_range(0, 5)], 5'($urandom_range(0, 2)), 6'($urandom)},
               $urandom_range(0, 3), -1, $urandom_range(0, 9) == 0);
      end
    end

`ifdef L1_I_PERF_CNT_EN
    check("perf_hits", hit_cnt, m_hits);
    check("perf_misses", miss_cnt, m_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_i_nway_controller.md
Name: l1_i_nway_controller

Overview:
- Parametrised successor to the 2-way L1 instruction-cache controller.
- N-way set-associative tag/valid store with tree pseudo-LRU replacement and configurable set count.
- Multi-cycle sequential flush.
- Sits between the core fetch stage (C) and L2. Handles lookup, miss request, refill-way selection and invalidation. The data array is external and is written using refill/way.

Parameters:
- WAYS, 4: associativity. Power of two, ≥2.
- TNUM, 21: L1 tag bits.
- INUM, 26-TNUM: L1 index bits. SETS = 2**INUM.
- TNUM_2, 18: L2 tag bits.
- INUM_2, 26-TNUM_2: L2 index bits.
- WNUM, $clog2(WAYS): way-select width.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- tag_C_L1  in  TNUM  fetch tag, address[31-:TNUM].
- index_C_L1  in  INUM  fetch index, address[6+:INUM].
- read_C_L1  in  1  fetch request.
- flush  in  1  invalidate-all request.
- ready_L2_L1  in  1  L2 line available.
- stall  out  1  core must hold the address.
- refill  out  1  one-cycle data-array write strobe.
- way  out  WNUM  hit way, or the victim way during refill.
- read_L1_L2  out  1  miss request to L2.
- index_L1_L2  out  INUM_2  block address re-split for L2.
- tag_L1_L2  out  TNUM_2  block address re-split for L2.

Behaviour:
- Reset (already decided): one clock, clk. Reset nrst is synchronous, active-low.
- While nrst is low at a clk edge:
  - state goes to IDLE.
  - All valid bits and PLRU bits are cleared.
  - All registered outputs go to 0; way=0.
  - Combinational stall=0.
- Block address: {tag_C_L1, index_C_L1} is 26 bits.
  - tag_L1_L2 = upper TNUM_2 bits.
  - index_L1_L2 = lower INUM_2 bits.
  - Both are taken from the miss-latched copy while in MISS.
- States: IDLE, MISS, REFILL, FLUSH.
- IDLE:
  - Lookup is combinational in the same cycle.
  - Hit = read_C_L1 and some way has valid && tag == tag_C_L1.
  - On hit: stall=0, way=hit way, PLRU updated at the edge.
  - On miss: stall=1 combinationally. Latch tag/index and victim, then go to MISS.
  - Victim = lowest-numbered invalid way; if all ways are valid, the PLRU victim.
  - If flush=1, go to FLUSH regardless of read; flush has priority.
- MISS:
  - stall=1, read_L1_L2=1.
  - Tag/index outputs are stable and unchanged until exit.
  - ready_L2_L1=1 → REFILL.
  - Input tag/index changes are ignored.
- REFILL (exactly 1 cycle):
  - refill=1, way=victim, stall=1.
  - At the edge: write the tag, set valid, update PLRU for the victim, clear read_L1_L2.
  - Then go to FLUSH if a flush is pending, else IDLE.
  - The next IDLE cycle with the same address hits.
- Flush pending: flush seen in MISS or REFILL sets a pending bit.
- FLUSH:
  - stall=1.
  - Counter walks index 0..SETS-1, one set per cycle, clearing all ways' valid and PLRU bits of that set.
  - Lasts exactly SETS cycles, then returns to IDLE.
  - Clears the pending bit.
  - flush held high in FLUSH is absorbed; no re-flush.
- ready_L2_L1 outside MISS is ignored.
- read_C_L1=0 in IDLE: stall=0, no state change.
- PLRU: tree of WAYS-1 bits per set.
  - Each node points away from the most recently accessed subtree.
  - The victim is found by following the pointers.

Optional Feature:
- Macro: L1_I_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE hit cycle.
  - miss_cnt increments on each IDLE→MISS transition.
  - Both counters saturate at 32'hFFFF_FFFF, clear on reset, and are not cleared by flush.
- Undefined: the ports and logic are absent.

Decomposition:
- Package l1_i_pkg holds:
  - the state enum (IDLE, MISS, REFILL, FLUSH);
  - the block-address width constant 26;
  - the line offset 6.
- Sub-module l1_i_plru_tree, parameter WAYS, is purely combinational:
  - inputs: the current tree bits and an access way;
  - outputs: the updated tree bits and the victim way.

Test Plan (WAYS=4, TNUM=21, INUM=5):
1. Reset, then read 32'h0000_0040.
   - stall=1 in the same cycle.
   - Next cycle: read_L1_L2=1, tag_L1_L2=0, index_L1_L2=8'h01.
   - Pulse ready_L2_L1 → refill=1, way=0 for one cycle.
   - The following cycle hits with stall=0.
2. Miss-fill four distinct tags at index 1 → victims are ways 0,1,2,3 in order.
3. After step 2, a fifth tag at index 1 → victim way 0. Then hit way 0 and miss a sixth tag → victim way 2.
4. Pulse flush in IDLE.
   - stall is high for exactly 32 cycles.
   - Re-reading the step-2 addresses all miss.
5. Assert flush during MISS.
   - Refill completes (refill=1), then FLUSH runs for 32 cycles.
   - The same address then misses.
6. Drive nrst=0 for one edge during MISS → read_L1_L2=0, stall=0, and a previously filled address misses.
